piso_serializer: RTL
====================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, number of data bits per word (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: din  input  WIDTH  parallel word to serialize.
REQ-005 SHALL have port: load_valid  input  1  din is valid this cycle.
REQ-006 SHALL have port: load_ready  output  1  block accepts a word this cycle.
REQ-007 SHALL have port: d  output  1  serial data, feeds the downstream serial-in parallel-out stage.
REQ-008 SHALL have port: d_valid  output  1  d carries a valid bit this cycle.
REQ-009 SHALL have port: done  output  1  one-cycle pulse marking the last bit of a word.

Function
REQ-010 SHALL have two FSM states: IDLE and SHIFT.
REQ-011 SHALL accept a word on the rising edge where load_valid && load_ready; all other load_valid cycles SHALL be ignored with no side effect.
REQ-012 SHALL present din[WIDTH-1] (MSB first) on d with d_valid=1 in the first cycle after acceptance (latency 1).
REQ-013 SHALL present each subsequent bit, MSB toward LSB, for exactly one cycle each, with no gaps.
REQ-014 SHALL keep d_valid=1 for exactly WIDTH consecutive cycles per word (WIDTH+1 with parity, REQ-027).
REQ-015 SHALL assert done for exactly the cycle in which the final bit of the word is on d.
REQ-016 SHALL hold the bit counter at 0..WIDTH-1 (0..WIDTH with parity); the counter SHALL be $clog2(WIDTH+1) bits wide and SHALL not wrap within a word.
REQ-017 SHALL assert load_ready in IDLE and in the final-bit cycle of SHIFT, and deassert it otherwise.
REQ-018 SHALL start the next word on the following cycle, with no idle cycle, when a word is accepted in the final-bit cycle (back-to-back).
REQ-019 SHALL return to IDLE after the final bit when no word is accepted in that cycle; in IDLE, d=0 and d_valid=0.
REQ-020 SHALL not let changes to din after acceptance affect the word in flight; the word SHALL be captured into an internal shift register.
REQ-021 SHALL not make d, d_valid or done depend combinationally on din or load_valid; all three SHALL be registered.

Reset
REQ-022 SHALL, while rst=0, force state=IDLE, shift register=0, counter=0, d=0, d_valid=0, done=0, load_ready=0.
REQ-023 SHALL assert load_ready=1 in the first cycle after rst deasserts.
REQ-024 SHALL, on reset asserted mid-word, abort the word immediately and not resume it after release.

Configuration
REQ-025 SHALL support macro PISO_PARITY_EN.
REQ-026 SHALL, without PISO_PARITY_EN, emit WIDTH bits per word.
REQ-027 SHALL, with PISO_PARITY_EN, append one even-parity bit (XOR of all WIDTH data bits) as the cycle after the LSB; done and the load_ready window SHALL move to the parity cycle.

Structure
REQ-028 SHALL place the state enum (IDLE, SHIFT) and the default WIDTH constant in shared package piso_pkg.
REQ-029 SHALL implement the bit counter as sub-module piso_bit_cnt (inputs: clear, enable, terminal count; output: last).

Verification
REQ-030 SHALL cover: WIDTH=4, reset, load din=4'b1011 -> d=1,0,1,1 over the 4 cycles after acceptance, d_valid high for 4 cycles, done on the 4th.
REQ-031 SHALL cover: load 4'b1100, then 4'b0011 held on load_valid in the final-bit cycle -> 8 contiguous valid bits 1,1,0,0,0,0,1,1 with no gap.
REQ-032 SHALL cover: load 4'b1111, toggle din and load_valid during SHIFT -> output stays 1,1,1,1; no extra word is accepted.
REQ-033 SHALL cover: rst low after the 2nd bit of 4'b1010 -> d=0, d_valid=0 immediately; after release, load_ready=1 and no residual bits.
REQ-034 SHALL cover: PISO_PARITY_EN, load 4'b0111 -> d=0,1,1,1,1 (parity 1), done on the 5th valid cycle.
REQ-035 SHALL cover: chained into the downstream 4-bit serial-in parallel-out stage, send 4'b1001 -> that stage's parallel output equals 4'b1001 after its pipeline latency.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in serial-out serializer.
package piso_pkg;

  localparam int unsigned PISO_WIDTH_DEFAULT = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit-position counter for the serializer. last_c flags that the value being
// loaded this edge equals the terminal count, so the caller can register it.
module piso_bit_cnt #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             last_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturates at term_i so the count never wraps within a word
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != term_i)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_c = (cnt_d == term_i);

endmodule

// File: rtl/piso_serializer.sv
// MSB-first parallel-to-serial converter with a valid/ready load port.
// Define PISO_PARITY_EN to append an even-parity bit after each word's LSB.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = PISO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             d,
  output logic             d_valid,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int unsigned SH_W = WIDTH + 1;
`else
  localparam int unsigned SH_W = WIDTH;
`endif
  localparam int unsigned       CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  TERM  = CNT_W'(SH_W - 1);

  piso_state_e     state_q, state_d;
  logic [SH_W-1:0] sh_q, sh_d;
  logic [SH_W-1:0] word_c;
  logic            d_q, d_d;
  logic            dv_q, dv_d;
  logic            done_q, done_d;
  logic            rdy_q, rdy_d;
  logic            accept_c;
  logic            cnt_clr_c;
  logic            cnt_en_c;
  logic            cnt_last_c;

`ifdef PISO_PARITY_EN
  assign word_c = {din, ^din};
`else
  assign word_c = din;
`endif

  assign accept_c = load_valid & rdy_q;

  // done_q marks the final-bit cycle, which is also the only SHIFT cycle
  // that can accept the next word
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    d_d       = 1'b0;
    dv_d      = 1'b0;
    cnt_clr_c = 1'b0;
    cnt_en_c  = 1'b0;
    if (accept_c) begin
      state_d   = SHIFT;
      sh_d      = word_c << 1;
      d_d       = word_c[SH_W-1];
      dv_d      = 1'b1;
      cnt_clr_c = 1'b1;
    end else if (state_q == SHIFT) begin
      if (done_q) begin
        state_d   = IDLE;
        sh_d      = '0;
        cnt_clr_c = 1'b1;
      end else begin
        sh_d     = sh_q << 1;
        d_d      = sh_q[SH_W-1];
        dv_d     = 1'b1;
        cnt_en_c = 1'b1;
      end
    end
  end

  assign done_d = dv_d & cnt_last_c;
  assign rdy_d  = (state_d == IDLE) | done_d;

  piso_bit_cnt #(
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (cnt_clr_c),
    .enable_i (cnt_en_c),
    .term_i   (TERM),
    .last_c   (cnt_last_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      d_q     <= 1'b0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      d_q     <= d_d;
      dv_q    <= dv_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign load_ready = rdy_q;
  assign d          = d_q;
  assign d_valid    = dv_q;
  assign done       = done_q;

endmodule
